dmem_lsu_ctrl: RTL and testbench
================================

DMEM_LSU_CTRL -- requirements
Module: dmem_lsu_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of request and memory ports.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  1  load/store request present.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_err  output  1  misaligned or illegal-size request; valid with resp_valid.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 mem_addr  output  ADDR_W  word-aligned address to data memory: {addr[ADDR_W-1:2], 2'b00}.
REQ-015 mem_read_en, mem_write_en  output  1 each  data memory strobes.
REQ-016 mem_byte_enable  output  4  always 4'b1111 while mem_write_en=1, else 0.
REQ-017 mem_wdata  output  32  full word to write.
REQ-018 mem_rdata  input  32  memory read data; valid only in the cycle after mem_read_en (1-cycle synchronous read).

Function
REQ-019 FSM states: IDLE, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_WR, RESP.
REQ-020 req_ready=1 only in IDLE with rst=0; handshake = req_valid & req_ready in cycle T; all request fields latched at T.
REQ-021 Misalignment: half with addr[0]=1, word with addr[1:0]!=0, size 11 -> IDLE->RESP, no memory strobe, resp_err=1 in T+1.
REQ-022 Load: LD_RD at T+1 (mem_read_en=1), LD_DATA at T+2 (sample mem_rdata), RESP at T+3 with resp_rdata.
REQ-023 Load extraction, little-endian: byte lane addr[1:0], half lane addr[1]; bit 7/15 extended per req_unsigned; word unchanged.
REQ-024 Word store: ST_WR at T+1 (mem_write_en=1, mem_wdata=req_wdata), RESP at T+2.
REQ-025 Byte/half store is read-modify-write: RMW_RD at T+1 (mem_read_en=1), RMW_WR at T+2 (mem_write_en=1, mem_wdata = mem_rdata with addressed lane replaced by req_wdata[7:0]/[15:0]), RESP at T+3.
REQ-026 mem_read_en and mem_write_en never both 1; mem_addr held constant from accept through RESP.
REQ-027 RESP lasts exactly one cycle, then IDLE; resp_valid has no backpressure; resp outputs 0 outside RESP.
REQ-028 Requests complete strictly in acceptance order; one outstanding request maximum; next accept earliest in cycle after RESP.
REQ-029 req_valid while req_ready=0 is ignored (no latch, no side effect); requester must hold it.

Reset
REQ-030 While rst=1: req_ready, resp_valid, resp_err, mem_read_en, mem_write_en, mem_byte_enable forced 0 combinationally, even mid-operation.
REQ-031 At the first edge with rst=1: state -> IDLE; resp_rdata, latched request, mem_addr, mem_wdata -> 0.
REQ-032 A request interrupted by reset is dropped: no memory write, no resp_valid; req_ready=1 in first cycle after rst falls.

Verification (memory preloaded 0xDEADBEEF)
REQ-033 SW addr 0x10 data 0x12345678 -> T+1 mem_write_en, mem_addr 0x10, be 1111; resp T+2; then LW 0x10 -> resp_rdata 0x12345678 at T+3.
REQ-034 SB addr 0x21 data 0xAA -> memory write 0xDEADAAEF; LBU 0x21 -> 0x000000AA; LB 0x21 -> 0xFFFFFFAA.
REQ-035 SH addr 0x32 data 0x1234 -> write 0x1234BEEF; LH 0x30 -> 0xFFFFBEEF; LHU 0x30 -> 0x0000BEEF.
REQ-036 LW 0x05, SH 0x33, size 11 -> resp_err=1 at T+1, resp_rdata 0, no memory strobe.
REQ-037 rst=1 during RMW_RD of SB 0x40 -> no mem_write_en, no resp_valid, word 0x40 stays 0xDEADBEEF, req_ready=1 first cycle after rst=0.
REQ-038 req_valid held high with LW then SW queued -> second accepted only in IDLE after first RESP; responses in order, no lost or duplicated request.

Source files
------------

// File: rtl/dmem_lsu_ctrl.sv
// Load/store unit controller for a word-wide, 1-cycle synchronous data memory.
// Accepts one byte/half/word request at a time. Loads are extracted and extended.
// Sub-word stores become read-modify-write sequences. Misaligned and
// illegal-size requests complete with an error and never touch memory.
module dmem_lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [3:0]        mem_byte_enable,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_RD   = 3'd1,
        LD_DATA = 3'd2,
        ST_WR   = 3'd3,
        RMW_RD  = 3'd4,
        RMW_WR  = 3'd5,
        RESP    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    // Illegal size, or a half/word whose address is not naturally aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Little-endian lane select followed by zero/sign extension.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Replace the addressed byte/half of the fetched word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        if (size == 2'b00) begin
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (lane[1]) begin
            r[31:16] = wdata[15:0];
        end else begin
            r[15:0] = wdata[15:0];
        end
        return r;
    endfunction

    // State and latched request registers; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: request latching, sequencing and load data capture.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = is_misaligned(req_size, req_addr[1:0]);
                    rdata_d = '0;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LD_RD;
                    end else if (req_size == 2'b10) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LD_RD:   state_d = LD_DATA;
            LD_DATA: begin
                rdata_d = load_extract(mem_rdata, size_q, uns_q, addr_q[1:0]);
                state_d = RESP;
            end
            ST_WR:   state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; reset masks every handshake and strobe immediately.
    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_err        = 1'b0;
        resp_rdata      = '0;
        mem_addr        = {addr_q[ADDR_W-1:2], 2'b00};
        mem_read_en     = 1'b0;
        mem_write_en    = 1'b0;
        mem_byte_enable = 4'b0000;
        mem_wdata       = '0;
        case (state_q)
            IDLE:   req_ready = 1'b1;
            LD_RD:  mem_read_en = 1'b1;
            RMW_RD: mem_read_en = 1'b1;
            ST_WR: begin
                mem_write_en    = 1'b1;
                mem_byte_enable = 4'b1111;
                mem_wdata       = wdata_q;
            end
            RMW_WR: begin
                mem_write_en    = 1'b1;
                mem_byte_enable = 4'b1111;
                mem_wdata       = store_merge(mem_rdata, size_q, addr_q[1:0], wdata_q);
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
            end
            default: ;
        endcase
        if (rst) begin
            req_ready       = 1'b0;
            resp_valid      = 1'b0;
            resp_err        = 1'b0;
            mem_read_en     = 1'b0;
            mem_write_en    = 1'b0;
            mem_byte_enable = 4'b0000;
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a 64-word synchronous memory model.
module tb_dmem_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];
    logic [31:0] last_waddr;
    logic [3:0]  last_be;
    int          n_writes = 0;

    dmem_lsu_ctrl #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .resp_rdata      (resp_rdata),
        .mem_addr        (mem_addr),
        .mem_read_en     (mem_read_en),
        .mem_write_en    (mem_write_en),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: byte-enabled write, 1-cycle read, junk when not reading.
    always @(posedge clk) begin
        if (mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_enable[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
            last_waddr <= mem_addr;
            last_be    <= mem_byte_enable;
            n_writes   <= n_writes + 1;
        end
        mem_rdata <= mem_read_en ? mem[mem_addr[7:2]] : 32'h0BAD0BAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request: checks ready, latency, error, data, strobe counts and conflicts.
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int lat, nrd, nwr, both;
        logic got, err;
        logic [31:0] rd;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        #1 chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; both = 0; got = 1'b0; err = 1'b0; rd = '0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (mem_read_en && mem_write_en) both++;
            if (mem_read_en) nrd++;
            if (mem_write_en) nwr++;
            if (resp_valid) begin
                got = 1'b1; lat = k; err = resp_err; rd = resp_rdata;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_nrd"}, nrd, (exp_err || (we && sz == 2'b10)) ? 0 : 1);
        chk({tag, "_nwr"}, nwr, (exp_err || !we) ? 0 : 1);
        chk({tag, "_both"}, both, 0);
        @(negedge clk);
        chk({tag, "_resp_one_cycle"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        int acc_k, r1_k, r2_k, nresp, nw0;
        logic [31:0] r1_data;
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEADBEEF;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        last_waddr = '0; last_be = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_strobes", {30'b0, mem_read_en, mem_write_en}, 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        // Word store then load back
        do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 2, 1'b0, 32'h0);
        chk("sw10_mem", mem[4], 32'h12345678);
        chk("sw10_waddr", last_waddr, 32'h10);
        chk("sw10_be", {28'b0, last_be}, 32'hF);
        do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'h12345678);

        // Byte store (RMW) and byte loads
        do_req("sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 3, 1'b0, 32'h0);
        chk("sb21_mem", mem[8], 32'hDEADAAEF);
        chk("sb21_waddr", last_waddr, 32'h20);
        chk("sb21_be", {28'b0, last_be}, 32'hF);
        do_req("lbu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 3, 1'b0, 32'h000000AA);
        do_req("lb21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 3, 1'b0, 32'hFFFFFFAA);
        do_req("lbu23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 3, 1'b0, 32'h000000DE);

        // Half store (RMW, upper lane) and half loads
        do_req("sh32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h00001234, 3, 1'b0, 32'h0);
        chk("sh32_mem", mem[12], 32'h1234BEEF);
        do_req("lh30", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 3, 1'b0, 32'hFFFFBEEF);
        do_req("lhu30", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 3, 1'b0, 32'h0000BEEF);
        do_req("lh32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 3, 1'b0, 32'h00001234);
        do_req("sh34", 1'b1, 2'b01, 1'b0, 32'h34, 32'h0000CAFE, 3, 1'b0, 32'h0);
        chk("sh34_mem", mem[13], 32'hDEADCAFE);

        // Misaligned and illegal-size requests
        nw0 = n_writes;
        do_req("lw05", 1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 1, 1'b1, 32'h0);
        do_req("sh33", 1'b1, 2'b01, 1'b0, 32'h33, 32'h0000FFFF, 1, 1'b1, 32'h0);
        do_req("sz11", 1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 1, 1'b1, 32'h0);
        do_req("sw12", 1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, 1, 1'b1, 32'h0);
        chk("err_no_writes", n_writes - nw0, 0);
        chk("sh33_mem", mem[12], 32'h1234BEEF);

        // Reset during RMW_RD of SB 0x40
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h40;
        req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 chk("rmw_rd_active", {31'b0, mem_read_en}, 32'd1);
        rst = 1'b1;
        #1 chk("rst_mask_rd", {31'b0, mem_read_en}, 32'd0);
        chk("rst_mask_ready", {31'b0, req_ready}, 32'd0);
        nw0 = n_writes; nresp = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_fall_ready", {31'b0, req_ready}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        chk("rst_drop_resp", nresp, 0);
        chk("rst_drop_write", n_writes - nw0, 0);
        chk("rst_drop_mem", mem[16], 32'hDEADBEEF);

        // Back-to-back: LW held then SW queued behind it
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        req_wdata = '0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
        acc_k = 0; r1_k = 0; r2_k = 0; nresp = 0; r1_data = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                nresp++;
                if (r1_k == 0) begin r1_k = k; r1_data = resp_rdata; end
                else r2_k = k;
            end
            if (req_ready && req_valid && acc_k == 0) begin
                acc_k = k;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("q_first_resp_k", r1_k, 3);
        chk("q_first_rdata", r1_data, 32'h12345678);
        chk("q_second_accept_k", acc_k, 4);
        chk("q_second_resp_k", r2_k, 6);
        chk("q_resp_count", nresp, 2);
        chk("q_sw_mem", mem[5], 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
